// File: rtl/uart_frame_parser.sv
// UART command-frame parser: HEADER | LEN | CMD | PARA[LEN-1] | CHK with checksum, LEN range and inter-byte timeout checks.
// Latency 1 clk from CHK strobe to o_frame_valid/o_err_*; one byte accepted per i_rx_en strobe, no backpressure.
module uart_frame_parser #(
    parameter int         MAX_PARA    = 4,
    parameter logic [7:0] HEADER      = 8'h40,
    parameter int         CHK_MODE    = 0,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rx_en,
    input  logic [7:0]            i_rx_data,
    output logic [7:0]            o_cmd,
    output logic [8*MAX_PARA-1:0] o_para,
    output logic [7:0]            o_para_cnt,
    output logic                  o_frame_valid,
    output logic                  o_err_chk,
    output logic                  o_err_len,
    output logic                  o_err_timeout,
    output logic                  o_busy
);

    localparam logic [2:0] S_HUNT = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_CMD  = 3'd2;
    localparam logic [2:0] S_PARA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [8:0]    LEN_MAX  = 9'(MAX_PARA + 1);

    logic [2:0]            state;
    logic [7:0]            acc;
    logic [7:0]            para_cnt;
    logic [7:0]            idx;
    logic [7:0]            cmd_stg;
    logic [8*MAX_PARA-1:0] para_stg;
    logic [TW-1:0]         timer;
    logic [7:0]            acc_next;
    logic                  timeout_hit;

    assign acc_next = (CHK_MODE != 0) ? (acc ^ i_rx_data) : (acc + i_rx_data);

    // The timer holds the number of idle cycles since the last byte; a byte on the expiry cycle wins.
    assign timeout_hit = (TIMEOUT_CYC > 0) && (state != S_HUNT) && !i_rx_en && (timer == TMO_LAST);

    assign o_busy = (state != S_HUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_HUNT;
            acc           <= '0;
            para_cnt      <= '0;
            idx           <= '0;
            cmd_stg       <= '0;
            para_stg      <= '0;
            timer         <= '0;
            o_cmd         <= '0;
            o_para        <= '0;
            o_para_cnt    <= '0;
            o_frame_valid <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            o_frame_valid <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_timeout <= 1'b0;

            if (state == S_HUNT || i_rx_en) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (timeout_hit) begin
                o_err_timeout <= 1'b1;
                state         <= S_HUNT;
            end else if (i_rx_en) begin
                case (state)
                    S_HUNT: begin
                        if (i_rx_data == HEADER) begin
                            acc      <= '0;
                            idx      <= '0;
                            para_stg <= '0;
                            state    <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (i_rx_data == 8'd0 || {1'b0, i_rx_data} > LEN_MAX) begin
                            o_err_len <= 1'b1;
                            state     <= S_HUNT;
                        end else begin
                            para_cnt <= i_rx_data - 8'd1;
                            acc      <= acc_next;
                            state    <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        cmd_stg <= i_rx_data;
                        acc     <= acc_next;
                        state   <= (para_cnt == 8'd0) ? S_CHK : S_PARA;
                    end
                    S_PARA: begin
                        for (int i = 0; i < MAX_PARA; i++) begin
                            if (idx == 8'(i)) begin
                                para_stg[i*8 +: 8] <= i_rx_data;
                            end
                        end
                        acc <= acc_next;
                        idx <= idx + 8'd1;
                        if (idx + 8'd1 == para_cnt) begin
                            state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (i_rx_data == acc) begin
                            o_cmd         <= cmd_stg;
                            o_para        <= para_stg;
                            o_para_cnt    <= para_cnt;
                            o_frame_valid <= 1'b1;
                        end else begin
                            o_err_chk <= 1'b1;
                        end
                        state <= S_HUNT;
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed vector table, timeout/reset sequences, randomized frames vs a frame-level model.
module tb_uart_frame_parser;

    localparam int         MP  = 4;
    localparam int         TMO = 100;
    localparam logic [7:0] HDR = 8'h40;

    localparam logic [3:0] EV_N = 4'b0000;
    localparam logic [3:0] EV_V = 4'b1000;
    localparam logic [3:0] EV_C = 4'b0100;
    localparam logic [3:0] EV_L = 4'b0010;
    localparam logic [3:0] EV_T = 4'b0001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_rx_en;
    logic [7:0]    i_rx_data;
    logic [7:0]    o_cmd;
    logic [8*MP-1:0] o_para;
    logic [7:0]    o_para_cnt;
    logic          o_frame_valid;
    logic          o_err_chk;
    logic          o_err_len;
    logic          o_err_timeout;
    logic          o_busy;

    uart_frame_parser #(
        .MAX_PARA    (MP),
        .HEADER      (HDR),
        .CHK_MODE    (0),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_en       (i_rx_en),
        .i_rx_data     (i_rx_data),
        .o_cmd         (o_cmd),
        .o_para        (o_para),
        .o_para_cnt    (o_para_cnt),
        .o_frame_valid (o_frame_valid),
        .o_err_chk     (o_err_chk),
        .o_err_len     (o_err_len),
        .o_err_timeout (o_err_timeout),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the held outputs of the last good frame.
    logic [7:0]  m_cmd;
    logic [31:0] m_para;
    logic [7:0]  m_cnt;

    typedef struct {
        logic [7:0]  b [8];
        int          n;
        logic [3:0]  ev;
        logic [7:0]  cmd;
        logic [31:0] para;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name);
        chk({name, "_cmd"}, 32'(o_cmd), 32'(m_cmd));
        chk({name, "_para"}, o_para, m_para);
        chk({name, "_cnt"}, 32'(o_para_cnt), 32'(m_cnt));
    endtask

    task automatic step(input logic en, input logic [7:0] d, output logic [3:0] ev);
        i_rx_en   = en;
        i_rx_data = d;
        @(posedge clk);
        @(negedge clk);
        ev = {o_frame_valid, o_err_chk, o_err_len, o_err_timeout};
        i_rx_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic [3:0] exp_ev, input string name);
        logic [3:0] ev;
        step(1'b1, b, ev);
        chk({name, "_ev"}, 32'(ev), 32'(exp_ev));
        chk_out(name);
    endtask

    task automatic idle(input int n, input int tmo_at, input string name);
        logic [3:0] ev;
        for (int i = 1; i <= n; i++) begin
            step(1'b0, 8'h00, ev);
            chk({name, "_idle_ev"}, 32'(ev), 32'((i == tmo_at) ? EV_T : EV_N));
        end
    endtask

    task automatic apply_vec(input int v, input string name);
        for (int i = 0; i < tbl[v].n; i++) begin
            if (i == tbl[v].n - 1) begin
                m_cmd  = tbl[v].cmd;
                m_para = tbl[v].para;
                m_cnt  = tbl[v].cnt;
            end
            send(tbl[v].b[i], (i == tbl[v].n - 1) ? tbl[v].ev : EV_N, name);
        end
    endtask

    task automatic rand_frame();
        logic [7:0] fb [$];
        logic [7:0] p [MP];
        logic [7:0] len, cmd, sum, b;
        int         np, r, abort_at, last;
        bit         ok_len, bad;

        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            b = 8'($urandom);
            if (b == HDR) b = 8'h00;
            send(b, EV_N, "rnd_hunt");
            idle($urandom_range(0, 2), 0, "rnd_hunt");
        end

        r = $urandom_range(0, 9);
        if (r == 0)      len = 8'd0;
        else if (r == 1) len = 8'($urandom_range(MP + 2, 255));
        else             len = 8'($urandom_range(1, MP + 1));
        ok_len = (len >= 1) && (len <= MP + 1);
        bad    = 1'b0;
        cmd    = 8'($urandom);
        np     = ok_len ? int'(len) - 1 : 0;

        fb.push_back(HDR);
        fb.push_back(len);
        if (ok_len) begin
            fb.push_back(cmd);
            sum = len + cmd;
            for (int k = 0; k < np; k++) begin
                p[k] = 8'($urandom);
                fb.push_back(p[k]);
                sum = sum + p[k];
            end
            bad = ($urandom_range(0, 3) == 0);
            fb.push_back(bad ? sum + 8'($urandom_range(1, 255)) : sum);
        end
        last     = fb.size() - 1;
        abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, last - 1)) : -1;

        for (int i = 0; i <= last; i++) begin
            if (i == last && ok_len && !bad) begin
                m_cmd  = cmd;
                m_cnt  = len - 8'd1;
                m_para = '0;
                for (int k = 0; k < np; k++) m_para[k*8 +: 8] = p[k];
            end
            send(fb[i], (i != last) ? EV_N : (!ok_len ? EV_L : (bad ? EV_C : EV_V)), "rnd");
            if (i == abort_at) begin
                idle(TMO + 3, TMO, "rnd_tmo");
                break;
            end
            if (i != last) begin
                idle(($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3)), 0, "rnd_gap");
            end
        end
        idle($urandom_range(0, 2), 0, "rnd_post");
    endtask

    initial begin
        tbl[0] = '{b: '{8'h40, 8'h05, 8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h50}, n: 8,
                   ev: EV_V, cmd: 8'hA1, para: 32'h44332211, cnt: 8'd4};
        tbl[1] = '{b: '{8'h40, 8'h02, 8'hB2, 8'h7F, 8'h33, 8'h00, 8'h00, 8'h00}, n: 5,
                   ev: EV_V, cmd: 8'hB2, para: 32'h0000007F, cnt: 8'd1};
        tbl[2] = '{b: '{8'h40, 8'h02, 8'hB2, 8'h7F, 8'h34, 8'h00, 8'h00, 8'h00}, n: 5,
                   ev: EV_C, cmd: 8'hB2, para: 32'h0000007F, cnt: 8'd1};
        tbl[3] = '{b: '{8'h40, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2,
                   ev: EV_L, cmd: 8'hB2, para: 32'h0000007F, cnt: 8'd1};
        tbl[4] = '{b: '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2,
                   ev: EV_L, cmd: 8'hB2, para: 32'h0000007F, cnt: 8'd1};
        tbl[5] = '{b: '{8'h40, 8'h01, 8'hC3, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4,
                   ev: EV_V, cmd: 8'hC3, para: 32'h00000000, cnt: 8'd0};
        // HEADER-valued bytes inside a frame are data: 03+40+40+40 = C3.
        tbl[6] = '{b: '{8'h40, 8'h03, 8'h40, 8'h40, 8'h40, 8'hC3, 8'h00, 8'h00}, n: 6,
                   ev: EV_V, cmd: 8'h40, para: 32'h00004040, cnt: 8'd2};

        rst_n     = 1'b0;
        i_rx_en   = 1'b0;
        i_rx_data = 8'h00;
        m_cmd     = '0;
        m_para    = '0;
        m_cnt     = '0;
        repeat (3) @(negedge clk);
        chk("reset_ev", 32'({o_frame_valid, o_err_chk, o_err_len, o_err_timeout}), 32'(EV_N));
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk_out("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors back to back: each HEADER follows the previous CHK strobe directly.
        for (int v = 0; v < 7; v++) apply_vec(v, $sformatf("vec%0d", v));
        idle(3, 0, "vec_tail");

        // Inter-byte timeout: exactly TMO cycles after the last strobe.
        send(8'h40, EV_N, "tmo");
        send(8'h05, EV_N, "tmo");
        send(8'hA1, EV_N, "tmo");
        chk("tmo_busy_before", 32'(o_busy), 32'd1);
        idle(TMO, TMO, "tmo");
        chk("tmo_busy_after", 32'(o_busy), 32'd0);
        chk_out("tmo_hold");
        apply_vec(0, "tmo_next");
        idle(2, 0, "tmo_next");

        // Reset mid-frame clears outputs and state.
        send(8'h40, EV_N, "rst");
        send(8'h05, EV_N, "rst");
        send(8'hA1, EV_N, "rst");
        send(8'h11, EV_N, "rst");
        chk("rst_busy_before", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        m_cmd  = '0;
        m_para = '0;
        m_cnt  = '0;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk_out("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_vec(0, "rst_next");
        idle(2, 0, "rst_next");

        for (int f = 0; f < 250; f++) rand_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
